decode_pipe_stage: RTL and testbench

- Parametrised successor to the current decode / ID-EX register stage.
- Reads operands from an internal 32-entry register file with write-through bypass. Extracts and sign-extends the immediate.
- Passes a pre-decoded control bundle through an ID/EX pipeline register that uses a valid/ready handshake.
- Has a 2-entry skid buffer so that in_ready_o is a registered signal.
- Held entries snoop writebacks, so stalled operands never go stale.

---
 rtl/decode_pkg.sv | 39 +++
 rtl/decode_rf.sv | 48 ++++
 rtl/decode_pipe_stage.sv | 186 ++++++++++++++++++
 tb/tb_decode_pipe_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the decode / ID-EX stage: instruction field
// positions, register file geometry and the ID/EX entry layout.
package decode_pkg;

    // Instruction field positions
    localparam int RD_MSB  = 24;
    localparam int RD_LSB  = 20;
    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 14;
    localparam int RS2_LSB = 10;
    localparam int IMM_MSB = 14;
    localparam int IMM_LSB = 0;
    // Low part of the split immediate (high part is the rd field)
    localparam int IMM_SPLIT_LO_MSB = 9;

    // Register file geometry
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    // Widths the ID/EX entry layout is built for
    localparam int PKG_XLEN   = 32;
    localparam int PKG_CTRL_W = 16;
    localparam int PKG_IMM_W  = 15;
    localparam int PC_W       = 32;

    typedef struct packed {
        logic                  valid;
        logic [PC_W-1:0]       pc;
        logic [REG_AW-1:0]     rd;
        logic [REG_AW-1:0]     rs1;
        logic [REG_AW-1:0]     rs2;
        logic [PKG_XLEN-1:0]   rs1_data;
        logic [PKG_XLEN-1:0]   rs2_data;
        logic [PKG_XLEN-1:0]   imm;
        logic [PKG_CTRL_W-1:0] ctrl;
    } id_ex_entry_t;

endpackage

// File: rtl/decode_rf.sv
// 32-entry register file: two combinational read ports with same-cycle
// write-through bypass, one write port, register 0 hardwired to zero.
module decode_rf
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    output logic [XLEN-1:0]   rdata1_o,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata2_o
);

    logic [XLEN-1:0] regs [NUM_REGS];

    // Storage update; writes to register 0 are dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    // Read ports: x0 is always zero, a same-cycle write to the index wins
    always_comb begin
        rdata1_o = regs[raddr1_i];
        rdata2_o = regs[raddr2_i];
        if (raddr1_i == '0) begin
            rdata1_o = '0;
        end else if (we_i && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
        if (raddr2_i == '0) begin
            rdata2_o = '0;
        end else if (we_i && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule

// File: rtl/decode_pipe_stage.sv
// Decode / ID-EX pipeline stage: operand read with bypass, immediate
// extraction, and a two-entry (main + skid) ID/EX buffer with a registered
// in_ready_o. Stored entries snoop writebacks so stalled operands stay fresh.
// Optional performance counters are enabled with DECODE_PERF_CNT_EN.
module decode_pipe_stage
    import decode_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int IMM_W  = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       instr_i,
    input  logic [31:0]       pc_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              split_imm_i,
    input  logic              flush_i,
    input  logic              wb_en_i,
    input  logic [4:0]        wb_dst_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       pc_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic [XLEN-1:0]   rs2_data_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [CTRL_W-1:0] ctrl_o
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    // The entry layout is fixed by the package; reject mismatched builds
    if (XLEN != PKG_XLEN || CTRL_W != PKG_CTRL_W || IMM_W != PKG_IMM_W) begin : g_param_check
        $error("decode_pipe_stage: parameters do not match decode_pkg entry layout");
    end

    // Sign-extend the raw immediate to the operand width
    function automatic logic signed [XLEN-1:0] sext_imm(input logic signed [IMM_W-1:0] raw);
        sext_imm = XLEN'(raw);
    endfunction

    // Refresh a stored entry's operands from a writeback to its sources
    function automatic id_ex_entry_t snoop(input id_ex_entry_t   e,
                                           input logic           en,
                                           input logic [4:0]     dst,
                                           input logic [XLEN-1:0] data);
        snoop = e;
        if (e.valid && en && (dst != '0)) begin
            if (dst == e.rs1) snoop.rs1_data = data;
            if (dst == e.rs2) snoop.rs2_data = data;
        end
    endfunction

    logic [REG_AW-1:0]        rd_p0, rs1_p0, rs2_p0;
    logic signed [IMM_W-1:0]  imm_raw_p0;
    logic [XLEN-1:0]          rs1_rd_p0, rs2_rd_p0;
    id_ex_entry_t             new_p0;

    id_ex_entry_t             main_p1, skid_p1;
    id_ex_entry_t             main_nxt, skid_nxt;
    logic                     in_ready_p1;

    logic                     accept, drain, main_free;
    id_ex_entry_t             main_snp, skid_snp;
    logic                     unused_instr_hi;

    assign rd_p0      = instr_i[RD_MSB:RD_LSB];
    assign rs1_p0     = instr_i[RS1_MSB:RS1_LSB];
    assign rs2_p0     = instr_i[RS2_MSB:RS2_LSB];
    assign imm_raw_p0 = split_imm_i ? {instr_i[RD_MSB:RD_LSB], instr_i[IMM_SPLIT_LO_MSB:0]}
                                    : instr_i[IMM_MSB:IMM_LSB];
    assign unused_instr_hi = ^instr_i[31:25];

    decode_rf #(.XLEN(XLEN)) u_rf (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_i     (wb_en_i),
        .waddr_i  (wb_dst_i),
        .wdata_i  (wb_data_i),
        .raddr1_i (rs1_p0),
        .rdata1_o (rs1_rd_p0),
        .raddr2_i (rs2_p0),
        .rdata2_o (rs2_rd_p0)
    );

    // Assemble the incoming entry from the decoded fields
    always_comb begin
        new_p0          = '0;
        new_p0.valid    = 1'b1;
        new_p0.pc       = pc_i;
        new_p0.rd       = rd_p0;
        new_p0.rs1      = rs1_p0;
        new_p0.rs2      = rs2_p0;
        new_p0.rs1_data = rs1_rd_p0;
        new_p0.rs2_data = rs2_rd_p0;
        new_p0.imm      = sext_imm(imm_raw_p0);
        new_p0.ctrl     = ctrl_i;
    end

    assign accept    = in_valid_i & in_ready_p1 & ~flush_i;
    assign drain     = main_p1.valid & out_ready_i;
    assign main_free = ~main_p1.valid | drain;
    assign main_snp  = snoop(main_p1, wb_en_i, wb_dst_i, wb_data_i);
    assign skid_snp  = snoop(skid_p1, wb_en_i, wb_dst_i, wb_data_i);

    // Next main/skid contents: flush, then skid-to-main move, then accept
    always_comb begin
        main_nxt = '0;
        skid_nxt = '0;
        if (flush_i) begin
            main_nxt = '0;
            skid_nxt = '0;
        end else if (main_free) begin
            if (skid_p1.valid) begin
                main_nxt = skid_snp;
                if (accept) skid_nxt = new_p0;
            end else if (accept) begin
                main_nxt = new_p0;
            end
        end else begin
            main_nxt = main_snp;
            if (skid_p1.valid) begin
                skid_nxt = skid_snp;
            end else if (accept) begin
                skid_nxt = new_p0;
            end
        end
    end

    // ---- ID/EX boundary ----
    // Main/skid entries and the registered ready
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_p1     <= '0;
            skid_p1     <= '0;
            in_ready_p1 <= 1'b1;
        end else begin
            main_p1     <= main_nxt;
            skid_p1     <= skid_nxt;
            in_ready_p1 <= ~skid_nxt.valid;
        end
    end

    assign in_ready_o  = in_ready_p1;
    assign out_valid_o = main_p1.valid;
    assign pc_o        = main_p1.pc;
    assign rd_o        = main_p1.rd;
    assign rs1_o       = main_p1.rs1;
    assign rs2_o       = main_p1.rs2;
    assign rs1_data_o  = main_p1.rs1_data;
    assign rs2_data_o  = main_p1.rs2_data;
    assign imm_o       = main_p1.imm;
    assign ctrl_o      = main_p1.valid ? main_p1.ctrl : '0;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;

    // Saturating stall and effective-flush counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_p1.valid && !out_ready_i && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush_i && (main_p1.valid || skid_p1.valid) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed testbench for decode_pipe_stage.
module tb_decode_pipe_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [15:0] ctrl_i;
    logic        split_imm_i;
    logic        flush_i;
    logic        wb_en_i;
    logic [4:0]  wb_dst_i;
    logic [31:0] wb_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] pc_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [31:0] rs1_data_o, rs2_data_o, imm_o;
    logic [15:0] ctrl_o;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    decode_pipe_stage dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .instr_i     (instr_i),
        .pc_i        (pc_i),
        .ctrl_i      (ctrl_i),
        .split_imm_i (split_imm_i),
        .flush_i     (flush_i),
        .wb_en_i     (wb_en_i),
        .wb_dst_i    (wb_dst_i),
        .wb_data_i   (wb_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .pc_o        (pc_o),
        .rd_o        (rd_o),
        .rs1_o       (rs1_o),
        .rs2_o       (rs2_o),
        .rs1_data_o  (rs1_data_o),
        .rs2_data_o  (rs2_data_o),
        .imm_o       (imm_o),
        .ctrl_o      (ctrl_o)
`ifdef DECODE_PERF_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [9:0] lo);
        mk = {7'b0, rd, rs1, rs2, lo};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [15:0] ctrl, input logic split);
        in_valid_i  = 1'b1;
        pc_i        = pc;
        instr_i     = instr;
        ctrl_i      = ctrl;
        split_imm_i = split;
    endtask

    task automatic wb(input logic en, input logic [4:0] dst, input logic [31:0] data);
        wb_en_i   = en;
        wb_dst_i  = dst;
        wb_data_i = data;
    endtask

    initial begin
        rst_i = 1'b1;
        in_valid_i = 1'b0; instr_i = '0; pc_i = '0; ctrl_i = '0; split_imm_i = 1'b0;
        flush_i = 1'b0; out_ready_i = 1'b1;
        wb(1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready_o}, 32'd1);
        chk("rst_pc",        pc_o, 32'd0);
        chk("rst_rs1_data",  rs1_data_o, 32'd0);
        chk("rst_imm",       imm_o, 32'd0);
        chk("rst_ctrl",      {16'd0, ctrl_o}, 32'd0);
        rst_i = 1'b0;
        tick();

        // Basic issue: x5 = DEADBEEF, ADD rd=3 rs1=5 rs2=0
        wb(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        drive(32'h100, mk(5'd3, 5'd5, 5'd0, 10'd0), 16'h0011, 1'b0);
        tick();
        in_valid_i = 1'b0;
        chk("add_valid",    {31'd0, out_valid_o}, 32'd1);
        chk("add_rs1_data", rs1_data_o, 32'hDEADBEEF);
        chk("add_rs2_data", rs2_data_o, 32'd0);
        chk("add_rd",       {27'd0, rd_o}, 32'd3);
        chk("add_pc",       pc_o, 32'h100);
        chk("add_ctrl",     {16'd0, ctrl_o}, 32'h0011);
        tick();
        chk("add_drained",  {31'd0, out_valid_o}, 32'd0);
        chk("idle_ctrl",    {16'd0, ctrl_o}, 32'd0);

        // Same-cycle writeback bypass on x7
        drive(32'h104, mk(5'd1, 5'd7, 5'd7, 10'd0), 16'h0022, 1'b0);
        wb(1'b1, 5'd7, 32'h1234);
        tick();
        in_valid_i = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        chk("byp_rs1_data", rs1_data_o, 32'h1234);
        chk("byp_rs2_data", rs2_data_o, 32'h1234);
        tick();

        // Stall: fill main and skid, snoop a writeback to x9, then drain in order
        out_ready_i = 1'b0;
        drive(32'h200, mk(5'd1, 5'd9, 5'd0, 10'd0), 16'h00A1, 1'b0);
        tick();
        chk("stl_ready_a", {31'd0, in_ready_o}, 32'd1);
        drive(32'h204, mk(5'd2, 5'd9, 5'd5, 10'd0), 16'h00B2, 1'b0);
        tick();
        in_valid_i = 1'b0;
        chk("stl_ready_b", {31'd0, in_ready_o}, 32'd0);
        chk("stl_pc_a",    pc_o, 32'h200);
        chk("stl_rs1_old", rs1_data_o, 32'd0);
        wb(1'b1, 5'd9, 32'hA5A5);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        chk("stl_snoop_a", rs1_data_o, 32'hA5A5);
        chk("stl_hold_pc", pc_o, 32'h200);
        out_ready_i = 1'b1;
        tick();
        chk("stl_valid_b",  {31'd0, out_valid_o}, 32'd1);
        chk("stl_pc_b",     pc_o, 32'h204);
        chk("stl_snoop_b",  rs1_data_o, 32'hA5A5);
        chk("stl_rs2_b",    rs2_data_o, 32'hDEADBEEF);
        chk("stl_ctrl_b",   {16'd0, ctrl_o}, 32'h00B2);
        chk("stl_ready_rt", {31'd0, in_ready_o}, 32'd1);
        tick();
        chk("stl_empty",    {31'd0, out_valid_o}, 32'd0);

        // Flush with both entries full and an instruction offered
        out_ready_i = 1'b0;
        drive(32'h300, mk(5'd4, 5'd5, 5'd0, 10'd0), 16'h0C01, 1'b0);
        tick();
        drive(32'h304, mk(5'd4, 5'd5, 5'd0, 10'd0), 16'h0C02, 1'b0);
        tick();
        chk("fl_full_ready", {31'd0, in_ready_o}, 32'd0);
        drive(32'h308, mk(5'd4, 5'd5, 5'd0, 10'd0), 16'h0C03, 1'b0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        chk("fl_valid", {31'd0, out_valid_o}, 32'd0);
        chk("fl_ctrl",  {16'd0, ctrl_o}, 32'd0);
        chk("fl_ready", {31'd0, in_ready_o}, 32'd1);
        out_ready_i = 1'b1;
        tick();
        chk("fl_gone",  {31'd0, out_valid_o}, 32'd0);
        drive(32'h30C, mk(5'd4, 5'd5, 5'd0, 10'd0), 16'h0C04, 1'b0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        chk("fl_no_accept", {31'd0, out_valid_o}, 32'd0);
        tick();

        // Immediates, issued back to back
        drive(32'h400, mk(5'b10000, 5'd0, 5'd0, 10'd0), 16'h0001, 1'b1);
        tick();
        chk("imm_split_neg", imm_o, 32'hFFFFC000);
        drive(32'h404, mk(5'b10000, 5'd0, 5'd0, 10'd0), 16'h0002, 1'b0);
        tick();
        chk("imm_same_nosplit", imm_o, 32'd0);
        chk("imm_b2b_pc", pc_o, 32'h404);
        drive(32'h408, mk(5'd0, 5'd0, 5'b10010, 10'h155), 16'h0003, 1'b0);
        tick();
        chk("imm_plain_neg", imm_o, 32'hFFFFC955);
        drive(32'h40C, mk(5'b01111, 5'd0, 5'd0, 10'h3FF), 16'h0004, 1'b1);
        tick();
        in_valid_i = 1'b0;
        chk("imm_split_pos", imm_o, 32'h00003FFF);
        tick();

        // Write to x0 while reading x0
        drive(32'h500, mk(5'd0, 5'd0, 5'd0, 10'd0), 16'h0005, 1'b0);
        wb(1'b1, 5'd0, 32'hFFFFFFFF);
        tick();
        in_valid_i = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        chk("x0_bypass", rs1_data_o, 32'd0);
        drive(32'h504, mk(5'd0, 5'd0, 5'd0, 10'd0), 16'h0006, 1'b0);
        tick();
        in_valid_i = 1'b0;
        chk("x0_stored", rs2_data_o, 32'd0);
        tick();

        // Asynchronous reset mid-stall with both entries full
        out_ready_i = 1'b0;
        drive(32'h600, mk(5'd6, 5'd5, 5'd5, 10'd1), 16'h0F01, 1'b0);
        tick();
        drive(32'h604, mk(5'd6, 5'd5, 5'd5, 10'd2), 16'h0F02, 1'b0);
        tick();
        in_valid_i = 1'b0;
        chk("ar_full_valid", {31'd0, out_valid_o}, 32'd1);
        chk("ar_full_ready", {31'd0, in_ready_o}, 32'd0);
        chk("ar_full_data",  rs1_data_o, 32'hDEADBEEF);
        #2;
        rst_i = 1'b1;
        #1;
        chk("ar_valid", {31'd0, out_valid_o}, 32'd0);
        chk("ar_ready", {31'd0, in_ready_o}, 32'd1);
        chk("ar_pc",    pc_o, 32'd0);
        chk("ar_rd",    {27'd0, rd_o}, 32'd0);
        chk("ar_rs1",   {27'd0, rs1_o}, 32'd0);
        chk("ar_data1", rs1_data_o, 32'd0);
        chk("ar_data2", rs2_data_o, 32'd0);
        chk("ar_imm",   imm_o, 32'd0);
        chk("ar_ctrl",  {16'd0, ctrl_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        tick();
        chk("ar_no_resurrect", {31'd0, out_valid_o}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            drive(32'h700 + 32'(i), mk(5'd0, 5'(i), 5'(i), 10'd0), 16'h0100, 1'b0);
            tick();
            chk("rf_zero_rs1", rs1_data_o, 32'd0);
            chk("rf_zero_rs2", rs2_data_o, 32'd0);
        end
        in_valid_i = 1'b0;
        chk("rf_last_pc", pc_o, 32'h71F);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
